// File: rtl/multicycle_controller.sv
// Multicycle RISC-V sequencing controller: Moore FSM driving datapath selects/enables plus retired counter.
// Optional JAL support is enabled by defining MULTICYCLE_JAL_EN.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             RegWrite,
    output logic             illegal_instr,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
        S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECUTER = 4'd6, S_EXECUTEI = 4'd7,
        S_ALUWB = 4'd8, S_BEQ = 4'd9, S_JAL = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I  = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;

    state_t     state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic       pc_update, branch, ir_write, mem_write, reg_write, adr_src, decode_bad;
    logic [1:0] alu_op, res_src, src_a, src_b;
    logic       unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        decode_bad = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
`ifdef MULTICYCLE_JAL_EN
                    OP_JAL:       state_d = S_JAL;
`endif
                    default:      decode_bad = 1'b1;
                endcase
            end
            S_MEMADR:                 state_d = Op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:                state_d = S_MEMWB;
            S_EXECUTER, S_EXECUTEI:   state_d = S_ALUWB;
            S_JAL:                    state_d = S_ALUWB;
            default:                  state_d = S_FETCH;
        endcase
    end

    // Only completed instructions count; illegal exits from DECODE do not.
    always_comb begin
        retired_d = retired_q;
        if (state_q == S_MEMWB || state_q == S_MEMWRITE || state_q == S_ALUWB || state_q == S_BEQ)
            retired_d = retired_q + CNT_W'(1);
    end

    always_comb begin
        pc_update = 1'b0; branch = 1'b0; ir_write = 1'b0; mem_write = 1'b0;
        reg_write = 1'b0; adr_src = 1'b0; alu_op = 2'b00; res_src = 2'b00;
        src_a = 2'b00; src_b = 2'b00;
        case (state_q)
            S_FETCH:    begin ir_write = 1'b1; src_b = 2'b10; res_src = 2'b10; pc_update = 1'b1; end
            S_DECODE:   begin src_a = 2'b01; src_b = 2'b01; end
            S_MEMADR:   begin src_a = 2'b10; src_b = 2'b01; end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB:    begin res_src = 2'b01; reg_write = 1'b1; end
            S_MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; end
            S_EXECUTER: begin src_a = 2'b10; alu_op = 2'b10; end
            S_EXECUTEI: begin src_a = 2'b10; src_b = 2'b01; alu_op = 2'b10; end
            S_ALUWB:    reg_write = 1'b1;
            S_BEQ:      begin src_a = 2'b10; alu_op = 2'b01; branch = 1'b1; end
            S_JAL:      begin src_a = 2'b01; src_b = 2'b10; pc_update = 1'b1; end
            default:    ;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (Op[5] & funct7[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (Op)
            OP_SW:  ImmSrc = 2'b01;
            OP_BEQ: ImmSrc = 2'b10;
`ifdef MULTICYCLE_JAL_EN
            OP_JAL: ImmSrc = 2'b11;
`endif
            default: ImmSrc = 2'b00;
        endcase
    end

    // Enables are gated by reset so nothing writes while the async reset is held.
    assign PCWrite       = ~reset & (pc_update | (branch & Zero));
    assign IRWrite       = ~reset & ir_write;
    assign MemWrite      = ~reset & mem_write;
    assign RegWrite      = ~reset & reg_write;
    assign illegal_instr = ~reset & (state_q == S_DECODE) & decode_bad;
    assign AdrSrc        = adr_src;
    assign ResultSrc     = res_src;
    assign ALUSrcA       = src_a;
    assign ALUSrcB       = src_b;
    assign state         = state_q;
    assign retired       = retired_q;
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle sequencing controller for the RISC-V core: a Moore FSM that steps each instruction through Fetch, Decode, Execute, Memory and Writeback over 3–5 cycles. It drives every datapath select and write enable: PC register, instruction register, shared memory, register file, ALU operand muxes and ALU operation. It sits directly upstream of the datapath and replaces the single-cycle `Control_Unit_Top` decode. It also maintains a retired-instruction counter.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `Op`  in  7: instruction opcode, `IR[6:0]`.
- `funct3`  in  3: `IR[14:12]`.
- `funct7`  in  7: `IR[31:25]`; only bit 5 is used.
- `Zero`  in  1: ALU zero flag.
- `PCWrite`  out  1: PC register load enable.
- `AdrSrc`  out  1: memory address select. 0 = PC, 1 = Result.
- `MemWrite`  out  1: memory write enable.
- `IRWrite`  out  1: instruction register and OldPC load enable.
- `ResultSrc`  out  2: result select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA`  out  2: ALU A select. 00 = PC, 01 = OldPC, 10 = RD1.
- `ALUSrcB`  out  2: ALU B select. 00 = RD2, 01 = ImmExt, 10 = constant 4.
- `ImmSrc`  out  2: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `ALUControl`  out  3: ALU operation. 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `RegWrite`  out  1: register file write enable.
- `illegal_instr`  out  1: one-cycle pulse in DECODE when the opcode is unsupported.
- `state`  out  4: current state, for debug.
- `retired`  out  CNT_W: retired-instruction count.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11–15 are unreachable; if entered, the next state is FETCH.
- Transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR on lw (0000011) or sw (0100011).
  - DECODE → EXECUTER on 0110011; → EXECUTEI on 0010011; → BEQ on 1100011; → JAL on 1101111.
  - DECODE → FETCH on any other opcode, with `illegal_instr`=1.
  - MEMADR → MEMREAD when `Op[5]`=0, else → MEMWRITE.
  - MEMREAD → MEMWB.
  - EXECUTER and EXECUTEI → ALUWB.
  - JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ → FETCH.
- Moore outputs (unlisted outputs are 0):
  - FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PC update.
  - DECODE: ALUSrcA=01, ALUSrcB=01 (computes branch target).
  - MEMADR: ALUSrcA=10, ALUSrcB=01.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PC update.
- `PCWrite` = PCUpdate | (Branch & `Zero`). This is the only Mealy term.
- `ImmSrc` is decoded combinationally from `Op`: lw/I-type → 00, sw → 01, beq → 10, jal → 11, other opcodes → 00.
- ALU decode:
  - ALUOp=00 → add; ALUOp=01 → sub.
  - ALUOp=10, `funct3`=000 → sub if {`Op[5]`,`funct7[5]`}=11, else add.
  - ALUOp=10, `funct3`=010 → slt; 110 → or; 111 → and; any other `funct3` → add.
- `retired` increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It wraps modulo 2^CNT_W. Illegal-opcode exits do not count.

## Timing
- Latency per instruction: lw 5 cycles, sw 4, R-type 4, I-type 4, beq 3, jal 4, illegal 2.
- The state register updates on `posedge clk`. All outputs are combinational from `state`, plus `Zero`, `Op`, `funct3` and `funct7`.
- While `reset`=1 (asynchronous):
  - `state`=FETCH and `retired`=0.
  - `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` and `illegal_instr` are forced to 0.
  - Select outputs hold their FETCH values: ALUSrcA=00, ALUSrcB=10, ResultSrc=10, AdrSrc=0, ALUControl=000.
- Reset asserted mid-instruction aborts immediately; no write enable asserts after the reset edge. The first FETCH executes on the first rising edge after `reset` deasserts.
- `Zero` is sampled only in BEQ. It must be stable before the rising edge ending BEQ.

## Configuration
- `MULTICYCLE_JAL_EN`:
  - Defined: the JAL state exists and opcode 1101111 executes in 4 cycles (rd ← OldPC+4, PC ← OldPC+ImmJ).
  - Undefined: 1101111 is treated as illegal (DECODE → FETCH with `illegal_instr`=1), and `ImmSrc` returns 00 for it.

## Test plan
- Reset mid-MEMWRITE, then release → `MemWrite` drops asynchronously; `state`=0 and `retired`=0; FETCH resumes on the next edge.
- lw (Op=0000011) → state sequence 0,1,2,3,4,0; `RegWrite`=1 only in state 4 with ResultSrc=01; `retired` increments by 1.
- sub R-type (Op=0110011, funct3=000, funct7=0100000) → ALUControl=001 in EXECUTERu; 4 cycles total.
- beq with `Zero`=1 → `PCWrite`=1 in BEQ; with `Zero`=0 → `PCWrite`=0; 3 cycles either way.
- Opcode 1111111 → `illegal_instr` pulses for exactly 1 cycle in DECODE; back to FETCH; `retired` unchanged.
- jal with the macro defined → states 0,1,10,8,0; without the macro → `illegal_instr`=1. Preload `retired` near 2^CNT_W−1 to check wrap to 0.
